idma_desc64_prefetch_ctrl: RTL and testbench



---
 rtl/idma_desc64_prefetch_ctrl_if.sv | 32 +++
 rtl/idma_desc64_prefetch_ctrl.sv | 158 +++++++++++++++
 tb/tb_idma_desc64_prefetch_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idma_desc64_prefetch_ctrl_if.sv
// Handshake bundle between the desc64 prefetch controller and its environment
// (head queue, AR channel, descriptor reader and R-burst gater).
interface idma_desc64_prefetch_ctrl_if #(
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned NSpeculation = 4
);
    localparam int unsigned FlushWidth = $clog2(NSpeculation + 1);

    logic [AddrWidth-1:0]  head_addr_i;
    logic                  head_valid_i;
    logic                  head_ready_o;
    logic [AddrWidth-1:0]  ar_addr_o;
    logic                  ar_valid_o;
    logic                  ar_ready_i;
    logic [AddrWidth-1:0]  desc_next_i;
    logic                  desc_valid_i;
    logic [FlushWidth-1:0] n_to_flush_o;
    logic                  n_to_flush_valid_o;
    logic                  busy_o;

    // Controller side.
    modport slave (
        input  head_addr_i, head_valid_i, ar_ready_i, desc_next_i, desc_valid_i,
        output head_ready_o, ar_addr_o, ar_valid_o, n_to_flush_o, n_to_flush_valid_o, busy_o
    );

    // Environment side.
    modport master (
        output head_addr_i, head_valid_i, ar_ready_i, desc_next_i, desc_valid_i,
        input  head_ready_o, ar_addr_o, ar_valid_o, n_to_flush_o, n_to_flush_valid_o, busy_o
    );
endinterface

// File: rtl/idma_desc64_prefetch_ctrl.sv
// Speculative descriptor-fetch scheduler: runs up to NSpeculation fetches ahead and flushes
// stale bursts on mispredict/end of chain. Define IDMA_DESC64_PREFETCH_STATS_EN for hit/miss counters.
module idma_desc64_prefetch_ctrl #(
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned NSpeculation = 4,
    parameter int unsigned DescBytes    = 32
) (
    input logic clk_i,
    input logic rst_ni,
    idma_desc64_prefetch_ctrl_if.slave bus
`ifdef IDMA_DESC64_PREFETCH_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);
    localparam int unsigned CntWidth = $clog2(NSpeculation + 1);

    typedef logic [CntWidth-1:0]  flush_t;
    typedef logic [AddrWidth-1:0] addr_t;

    localparam addr_t  Stride      = addr_t'(DescBytes);
    localparam addr_t  EndMarker   = '1;
    localparam flush_t MaxInflight = flush_t'(NSpeculation);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

    state_e state_q, state_d;
    addr_t  fetch_addr_q, fetch_addr_d;
    addr_t  expect_addr_q, expect_addr_d;
    flush_t inflight_q, inflight_d;
    logic   end_q, end_d;

    logic   ar_valid, ar_acc, ar_pend;
    logic   desc_fetch, desc_hit, desc_end, flush_valid;
    flush_t n_flush;

    always_comb begin
        // In FETCH a pending AR can only coexist with inflight < NSpeculation, so the
        // occupancy term alone keeps ar_valid stable until the handshake.
        ar_valid    = (state_q == StHold) || ((state_q == StFetch) && (inflight_q < MaxInflight));
        ar_acc      = ar_valid && bus.ar_ready_i;
        ar_pend     = ar_valid && !bus.ar_ready_i;
        desc_fetch  = (state_q == StFetch) && bus.desc_valid_i;
        desc_hit    = (bus.desc_next_i == expect_addr_q + Stride);
        desc_end    = (bus.desc_next_i == EndMarker);
        flush_valid = desc_fetch && !desc_hit;
        n_flush     = inflight_q - flush_t'(1) + flush_t'(ar_acc) + flush_t'(ar_pend);
    end

    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        expect_addr_d = expect_addr_q;
        inflight_d    = inflight_q;
        end_d         = end_q;

        unique case (state_q)
            StIdle: begin
                if (bus.head_valid_i) begin
                    fetch_addr_d  = bus.head_addr_i;
                    expect_addr_d = bus.head_addr_i;
                    inflight_d    = '0;
                    state_d       = StFetch;
                end
            end
            StFetch: begin
                if (ar_acc) begin
                    fetch_addr_d = fetch_addr_q + Stride;
                    inflight_d   = inflight_q + flush_t'(1);
                end
                if (bus.desc_valid_i) begin
                    if (desc_hit) begin
                        expect_addr_d = expect_addr_q + Stride;
                        inflight_d    = inflight_q + flush_t'(ar_acc) - flush_t'(1);
                    end else begin
                        inflight_d = '0;
                        if (!desc_end) begin
                            expect_addr_d = bus.desc_next_i;
                        end
                        if (ar_pend) begin
                            // fetch_addr_q keeps driving the stale AR; the redirect target
                            // waits in expect_addr_q until HOLD drains.
                            end_d   = desc_end;
                            state_d = StHold;
                        end else if (desc_end) begin
                            state_d = StIdle;
                        end else begin
                            fetch_addr_d = bus.desc_next_i;
                        end
                    end
                end
            end
            StHold: begin
                if (bus.ar_ready_i) begin
                    if (end_q) begin
                        state_d = StIdle;
                    end else begin
                        fetch_addr_d = expect_addr_q;
                        state_d      = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            fetch_addr_q  <= '0;
            expect_addr_q <= '0;
            inflight_q    <= '0;
            end_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            expect_addr_q <= expect_addr_d;
            inflight_q    <= inflight_d;
            end_q         <= end_d;
        end
    end

    assign bus.head_ready_o       = (state_q == StIdle);
    assign bus.ar_valid_o         = ar_valid;
    assign bus.ar_addr_o          = fetch_addr_q;
    assign bus.n_to_flush_valid_o = flush_valid;
    assign bus.n_to_flush_o       = flush_valid ? n_flush : '0;
    assign bus.busy_o             = (state_q != StIdle) || (inflight_q != '0);

`ifdef IDMA_DESC64_PREFETCH_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (desc_fetch && desc_hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (flush_valid && !desc_end && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

`ifndef SYNTHESIS
    desc_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.desc_valid_i |-> ((state_q == StFetch) && (inflight_q != '0)));
    flush_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        flush_valid |-> (n_flush <= MaxInflight));
`endif
endmodule

// File: tb/tb_idma_desc64_prefetch_ctrl.sv
// Self-checking bench for idma_desc64_prefetch_ctrl: directed scenarios plus a randomized
// run against a queue-based model of outstanding descriptor fetches.
module tb_idma_desc64_prefetch_ctrl;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned NSpec     = 4;
    localparam int unsigned DescBytes = 32;
    localparam logic [63:0] AllOnes   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    idma_desc64_prefetch_ctrl_if #(.AddrWidth(AddrWidth), .NSpeculation(NSpec)) bus ();

    idma_desc64_prefetch_ctrl #(
        .AddrWidth   (AddrWidth),
        .NSpeculation(NSpec),
        .DescBytes   (DescBytes)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic drive(input logic hv, input logic [63:0] ha, input logic rdy,
                         input logic dv, input logic [63:0] dn);
        bus.head_valid_i = hv;
        bus.head_addr_i  = ha;
        bus.ar_ready_i   = rdy;
        bus.desc_valid_i = dv;
        bus.desc_next_i  = dn;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        n_total++; if (bus.head_ready_o !== 1'b1)
            $display("FAIL reset_head_ready: got %b want 1", bus.head_ready_o); else n_pass++;
        n_total++; if (bus.ar_valid_o !== 1'b0)
            $display("FAIL reset_ar_valid: got %b want 0", bus.ar_valid_o); else n_pass++;
        n_total++; if (bus.ar_addr_o !== 64'h0)
            $display("FAIL reset_ar_addr: got %h want 0", bus.ar_addr_o); else n_pass++;
        n_total++; if (bus.busy_o !== 1'b0)
            $display("FAIL reset_busy: got %b want 0", bus.busy_o); else n_pass++;
        n_total++; if (bus.n_to_flush_valid_o !== 1'b0 || bus.n_to_flush_o !== 3'd0)
            $display("FAIL reset_flush: got %b/%0d want 0/0",
                     bus.n_to_flush_valid_o, bus.n_to_flush_o); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_total++; if (bus.head_ready_o !== 1'b1 || bus.busy_o !== 1'b0)
            $display("FAIL post_reset_idle: got ready=%b busy=%b want 1/0",
                     bus.head_ready_o, bus.busy_o); else n_pass++;
    endtask

    // Head 0x1000 with ar_ready held high: four back-to-back ARs, then the window is full.
    task automatic test_fill();
        drive(1'b1, 64'h1000, 1'b1, 1'b0, 64'h0);
        n_total++; if (bus.head_ready_o !== 1'b1)
            $display("FAIL fill_head_ready: got %b want 1", bus.head_ready_o); else n_pass++;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
            n_total++; if (bus.ar_valid_o !== 1'b1 || bus.ar_addr_o !== 64'h1000 + 64'(32 * i))
                $display("FAIL fill_ar[%0d]: got %b/%h want 1/%h", i, bus.ar_valid_o,
                         bus.ar_addr_o, 64'h1000 + 64'(32 * i)); else n_pass++;
            tick();
        end
        drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
        n_total++; if (bus.ar_valid_o !== 1'b0)
            $display("FAIL fill_full: got ar_valid %b want 0", bus.ar_valid_o); else n_pass++;
        n_total++; if (bus.busy_o !== 1'b1 || bus.head_ready_o !== 1'b0)
            $display("FAIL fill_busy: got busy=%b ready=%b want 1/0",
                     bus.busy_o, bus.head_ready_o); else n_pass++;
    endtask

    // Continues from test_fill: 0x1000 hits, refill at 0x1080, 0x1020 ends the chain.
    task automatic test_hit_end();
        drive(1'b0, 64'h0, 1'b1, 1'b1, 64'h1020);
        n_total++; if (bus.n_to_flush_valid_o !== 1'b0)
            $display("FAIL hit_no_flush: got %b want 0", bus.n_to_flush_valid_o); else n_pass++;
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
        n_total++; if (bus.ar_valid_o !== 1'b1 || bus.ar_addr_o !== 64'h1080)
            $display("FAIL hit_refill: got %b/%h want 1/1080",
                     bus.ar_valid_o, bus.ar_addr_o); else n_pass++;
        tick();
        // Outstanding after delivering 0x1020: 0x1040, 0x1060, 0x1080.
        drive(1'b0, 64'h0, 1'b1, 1'b1, AllOnes);
        n_total++; if (bus.n_to_flush_valid_o !== 1'b1 || bus.n_to_flush_o !== 3'd3)
            $display("FAIL end_flush: got %b/%0d want 1/3",
                     bus.n_to_flush_valid_o, bus.n_to_flush_o); else n_pass++;
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
        n_total++; if (bus.head_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.ar_valid_o !== 1'b0)
            $display("FAIL end_idle: got ready=%b busy=%b arv=%b want 1/0/0",
                     bus.head_ready_o, bus.busy_o, bus.ar_valid_o); else n_pass++;
    endtask

    task automatic test_mispredict();
        do_reset();
        drive(1'b1, 64'h1000, 1'b1, 1'b0, 64'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b1, 1'b1, 64'h8000);
        n_total++; if (bus.n_to_flush_valid_o !== 1'b1 || bus.n_to_flush_o !== 3'd3)
            $display("FAIL mis_flush: got %b/%0d want 1/3",
                     bus.n_to_flush_valid_o, bus.n_to_flush_o); else n_pass++;
        tick();
        drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
        n_total++; if (bus.ar_valid_o !== 1'b1 || bus.ar_addr_o !== 64'h8000)
            $display("FAIL mis_redirect: got %b/%h want 1/8000",
                     bus.ar_valid_o, bus.ar_addr_o); else n_pass++;
        tick();
    endtask

    // Mispredict while the refill AR at 0x1080 is stalled: it must stay put through HOLD.
    task automatic test_hold();
        do_reset();
        drive(1'b1, 64'h1000, 1'b1, 1'b0, 64'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b1, 64'h1020);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 64'h0, 1'b0, (k == 2), 64'h8000);
            n_total++; if (bus.ar_valid_o !== 1'b1 || bus.ar_addr_o !== 64'h1080)
                $display("FAIL hold_stable[%0d]: got %b/%h want 1/1080", k,
                         bus.ar_valid_o, bus.ar_addr_o); else n_pass++;
            n_total++; if (bus.n_to_flush_valid_o !== (k == 2))
                $display("FAIL hold_pulse[%0d]: got %b want %b", k,
                         bus.n_to_flush_valid_o, (k == 2)); else n_pass++;
            if (k == 2) begin
                n_total++; if (bus.n_to_flush_o !== 3'd3)
                    $display("FAIL hold_count: got %0d want 3", bus.n_to_flush_o); else n_pass++;
            end
            tick();
        end
        drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
        n_total++; if (bus.ar_valid_o !== 1'b1 || bus.ar_addr_o !== 64'h1080 || bus.busy_o !== 1'b1)
            $display("FAIL hold_release: got %b/%h busy=%b want 1/1080/1",
                     bus.ar_valid_o, bus.ar_addr_o, bus.busy_o); else n_pass++;
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        n_total++; if (bus.ar_valid_o !== 1'b1 || bus.ar_addr_o !== 64'h8000)
            $display("FAIL hold_redirect: got %b/%h want 1/8000",
                     bus.ar_valid_o, bus.ar_addr_o); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [63:0] want;
        do_reset();
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 1'b0, 64'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            want = 64'hFFFF_FFFF_FFFF_FFC0 + 64'(32 * i);
            drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
            n_total++; if (bus.ar_valid_o !== 1'b1 || bus.ar_addr_o !== want)
                $display("FAIL wrap_ar[%0d]: got %b/%h want 1/%h", i,
                         bus.ar_valid_o, bus.ar_addr_o, want); else n_pass++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 64'h2000, 1'b1, 1'b0, 64'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        n_total++; if (bus.busy_o !== 1'b1 || bus.ar_valid_o !== 1'b1)
            $display("FAIL arst_pre: got busy=%b arv=%b want 1/1",
                     bus.busy_o, bus.ar_valid_o); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.head_ready_o !== 1'b1 || bus.ar_valid_o !== 1'b0 ||
                       bus.busy_o !== 1'b0 || bus.ar_addr_o !== 64'h0)
            $display("FAIL arst_async: got ready=%b arv=%b busy=%b addr=%h want 1/0/0/0",
                     bus.head_ready_o, bus.ar_valid_o, bus.busy_o, bus.ar_addr_o); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++; if (bus.n_to_flush_valid_o !== 1'b0)
                $display("FAIL arst_no_flush[%0d]: got %b want 0", i,
                         bus.n_to_flush_valid_o); else n_pass++;
        end
        rst_n = 1'b1;
        drive(1'b1, 64'h3000, 1'b0, 1'b0, 64'h0);
        n_total++; if (bus.head_ready_o !== 1'b1)
            $display("FAIL arst_head_ready: got %b want 1", bus.head_ready_o); else n_pass++;
        tick();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        n_total++; if (bus.ar_valid_o !== 1'b1 || bus.ar_addr_o !== 64'h3000)
            $display("FAIL arst_new_head: got %b/%h want 1/3000",
                     bus.ar_valid_o, bus.ar_addr_o); else n_pass++;
    endtask

    // Model: q holds addresses fetched and not yet delivered (oldest first); a stale AR left
    // pending at a flush is tracked separately and must be drained before fetching resumes.
    task automatic test_random();
        logic [63:0] q[$];
        logic [63:0] exp_fetch, stale_addr, redirect, a, nx, ha;
        logic [2:0]  exp_n;
        bit          idle, stale, stale_end, was_pend, rdy, dv, acc, pend, hit, exp_valid;
        int          r;
        do_reset();
        idle = 1'b1; stale = 1'b0; stale_end = 1'b0; was_pend = 1'b0;
        exp_fetch = '0; stale_addr = '0; redirect = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            ha = {$urandom(), $urandom()} & ~64'h1F;
            if ($urandom_range(0, 9) == 0) ha = 64'hFFFF_FFFF_FFFF_FF00 | (ha & 64'hE0);
            if (idle) begin
                drive(1'b1, ha, 1'b0, 1'b0, 64'h0);
                n_total++; if (bus.head_ready_o !== 1'b1 || bus.busy_o !== 1'b0 ||
                               bus.ar_valid_o !== 1'b0)
                    $display("FAIL rnd_idle[%0d]: got ready=%b busy=%b arv=%b want 1/0/0", cyc,
                             bus.head_ready_o, bus.busy_o, bus.ar_valid_o); else n_pass++;
                q.delete();
                exp_fetch = ha;
                idle      = 1'b0;
                was_pend  = 1'b0;
                tick();
                continue;
            end
            rdy = ($urandom_range(0, 9) < 6);
            dv  = (q.size() != 0) && !stale && ($urandom_range(0, 9) < 4);
            a   = dv ? q[0] : 64'h0;
            r   = $urandom_range(0, 19);
            if (r < 15)      nx = a + 64'd32;
            else if (r < 17) nx = AllOnes;
            else             nx = {$urandom(), $urandom()} & ~64'h1F;
            drive(1'($urandom_range(0, 1)), ha, rdy, dv, nx);
            exp_valid = stale || was_pend || (q.size() < NSpec);
            n_total++; if (bus.head_ready_o !== 1'b0 || bus.busy_o !== 1'b1 ||
                           bus.ar_valid_o !== exp_valid)
                $display("FAIL rnd_state[%0d]: got ready=%b busy=%b arv=%b want 0/1/%b", cyc,
                         bus.head_ready_o, bus.busy_o, bus.ar_valid_o, exp_valid); else n_pass++;
            if (exp_valid) begin
                n_total++; if (bus.ar_addr_o !== (stale ? stale_addr : exp_fetch))
                    $display("FAIL rnd_ar_addr[%0d]: got %h want %h", cyc, bus.ar_addr_o,
                             stale ? stale_addr : exp_fetch); else n_pass++;
            end
            acc  = exp_valid && rdy;
            pend = exp_valid && !rdy;
            if (dv) begin
                void'(q.pop_front());
                hit = (nx == a + 64'd32);
                n_total++; if (bus.n_to_flush_valid_o !== !hit)
                    $display("FAIL rnd_pulse[%0d]: got %b want %b", cyc,
                             bus.n_to_flush_valid_o, !hit); else n_pass++;
                if (!hit) begin
                    exp_n = 3'(q.size() + int'(acc) + int'(pend));
                    n_total++; if (bus.n_to_flush_o !== exp_n)
                        $display("FAIL rnd_count[%0d]: got %0d want %0d", cyc,
                                 bus.n_to_flush_o, exp_n); else n_pass++;
                    q.delete();
                    if (pend) begin
                        stale      = 1'b1;
                        stale_addr = exp_fetch;
                        stale_end  = (nx == AllOnes);
                        redirect   = nx;
                    end else if (nx == AllOnes) begin
                        idle = 1'b1;
                    end else begin
                        exp_fetch = nx;
                    end
                end else if (acc) begin
                    q.push_back(exp_fetch);
                    exp_fetch = exp_fetch + 64'd32;
                end
            end else begin
                n_total++; if (bus.n_to_flush_valid_o !== 1'b0)
                    $display("FAIL rnd_spurious[%0d]: got %b want 0", cyc,
                             bus.n_to_flush_valid_o); else n_pass++;
                if (acc && stale) begin
                    stale = 1'b0;
                    if (stale_end) idle = 1'b1;
                    else           exp_fetch = redirect;
                end else if (acc) begin
                    q.push_back(exp_fetch);
                    exp_fetch = exp_fetch + 64'd32;
                end
            end
            was_pend = pend && !stale && !idle && !(dv && !hit);
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_hit_end();
        test_mispredict();
        test_hold();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
